// File: rtl/div_pkg.sv
// Shared types for the shift-and-subtract divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Request/result bundle between the arithmetic unit and the divider.
// Master issues Start with operands; slave returns status and results.
interface shift_sub_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Div_By_Zero;

  modport master (
    output Start,
    output Dividend,
    output Divisor,
    input  Busy,
    input  Done,
    input  Quotient,
    input  Remainder,
    input  Div_By_Zero
  );

  modport slave (
    input  Start,
    input  Dividend,
    input  Divisor,
    output Busy,
    output Done,
    output Quotient,
    output Remainder,
    output Div_By_Zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-and-subtract iteration, purely combinational.
// Partial remainder is WIDTH+1 bits so the compare never overflows.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] qsh_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] qsh_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dext;

  always_comb begin
    shifted = {r_i[WIDTH-1:0], qsh_i[WIDTH-1]};
    dext    = {1'b0, d_i};
    r_o     = shifted;
    qsh_o   = {qsh_i[WIDTH-2:0], 1'b0};
    if (shifted >= dext) begin
      r_o      = shifted - dext;
      qsh_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Holds the FSM, iteration counter and all result registers.
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  shift_sub_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] qsh_nxt;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i   (r_q),
    .qsh_i (qsh_q),
    .d_i   (d_q),
    .r_o   (r_nxt),
    .qsh_o (qsh_nxt)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    qsh_d   = qsh_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.Divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.Dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            qsh_d   = bus.Dividend;
            r_d     = '0;
            d_d     = bus.Divisor;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        r_d   = r_nxt;
        qsh_d = qsh_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = qsh_nxt;
          rem_d   = r_nxt[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      qsh_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      qsh_q   <= qsh_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Busy        = (state_q == RUN);
  assign bus.Done        = (state_q == DONE);
  assign bus.Quotient    = quo_q;
  assign bus.Remainder   = rem_q;
  assign bus.Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and randomized checks of the shift-and-subtract divider.
// Expected results come from plain integer division.
module tb_shift_sub_divider;

  localparam int W = 32;
  localparam int TMO = 100;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  shift_sub_divider_if #(.WIDTH(W)) bus ();

  shift_sub_divider #(
    .WIDTH (W)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b);
    @(negedge Clock);
    bus.Start    = 1'b1;
    bus.Dividend = a;
    bus.Divisor  = b;
    @(negedge Clock);
    bus.Start    = 1'b0;
    bus.Dividend = $urandom;
    bus.Divisor  = $urandom;
  endtask

  // Called right after start_op: cyc counts edges after the sampling edge + 1.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.Done !== 1'b1 && cyc < TMO) begin
      @(negedge Clock);
      cyc++;
    end
    if (cyc >= TMO) chk("done_timeout", 64'(cyc), 64'(0));
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      if (bus.Done === 1'b1) cnt++;
    end
  endtask

  task automatic check_res(input string tag,
                           input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [63:0] eq;
    logic [63:0] er;
    logic [63:0] q;
    logic [63:0] r;
    if (b == 0) begin
      eq = 64'({W{1'b1}});
      er = 64'(a);
    end else begin
      eq = 64'(a) / 64'(b);
      er = 64'(a) % 64'(b);
    end
    q = 64'(bus.Quotient);
    r = 64'(bus.Remainder);
    chk({tag, "_quo"}, q, eq);
    chk({tag, "_rem"}, r, er);
    chk({tag, "_dbz"}, 64'(bus.Div_By_Zero), 64'(b == 0));
    if (b != 0)
      chk({tag, "_inv"},
          64'((q * 64'(b) + r == 64'(a)) && (r < 64'(b))), 64'd1);
  endtask

  initial begin
    int cyc;
    int nd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int kind;
    checks = 0;
    errors = 0;
    bus.Start    = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    Reset = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_quo", 64'(bus.Quotient), 64'd0);
    chk("rst_rem", 64'(bus.Remainder), 64'd0);
    chk("rst_dbz", 64'(bus.Div_By_Zero), 64'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;

    // 100 / 7 with latency
    start_op(100, 7);
    chk("d1_busy", 64'(bus.Busy), 64'd1);
    wait_done(cyc);
    chk("d1_lat", 64'(cyc), 64'(W));
    chk("d1_busy_off", 64'(bus.Busy), 64'd0);
    check_res("d1", 100, 7);

    // back to back at earliest accepted edge
    start_op('1, 1);
    wait_done(cyc);
    chk("b2b1_lat", 64'(cyc), 64'(W));
    check_res("b2b1", '1, 1);
    start_op(3, 10);
    wait_done(cyc);
    chk("b2b2_lat", 64'(cyc), 64'(W));
    check_res("b2b2", 3, 10);

    // divide by zero
    start_op(5, 0);
    chk("dz_busy", 64'(bus.Busy), 64'd0);
    wait_done(cyc);
    chk("dz_lat", 64'(cyc), 64'd0);
    check_res("dz", 5, 0);

    // Start during DONE is ignored
    start_op(1000, 3);
    wait_done(cyc);
    bus.Start    = 1'b1;
    bus.Dividend = 7;
    bus.Divisor  = 7;
    @(negedge Clock);
    bus.Start = 1'b0;
    chk("sdone_busy", 64'(bus.Busy), 64'd0);
    count_done(W + 5, nd);
    chk("sdone_nodone", 64'(nd), 64'd0);
    check_res("sdone", 1000, 3);

    // Start during RUN is ignored
    start_op(1000, 3);
    repeat (5) @(negedge Clock);
    bus.Start    = 1'b1;
    bus.Dividend = 9;
    bus.Divisor  = 2;
    @(negedge Clock);
    bus.Start = 1'b0;
    wait_done(cyc);
    check_res("srun", 1000, 3);
    count_done(W + 5, nd);
    chk("srun_nodone", 64'(nd), 64'd0);

    // reset mid-run
    start_op(12345, 17);
    repeat (10) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("mr_busy", 64'(bus.Busy), 64'd0);
    chk("mr_done", 64'(bus.Done), 64'd0);
    chk("mr_quo", 64'(bus.Quotient), 64'd0);
    chk("mr_rem", 64'(bus.Remainder), 64'd0);
    chk("mr_dbz", 64'(bus.Div_By_Zero), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    count_done(W + 5, nd);
    chk("mr_nodone", 64'(nd), 64'd0);
    start_op(50, 5);
    wait_done(cyc);
    chk("mr_lat", 64'(cyc), 64'(W));
    check_res("mr", 50, 5);

    // randomized pairs
    for (int i = 0; i < 1500; i++) begin
      kind = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (kind)
        0: a = '0;
        1: b = '0;
        2: b = W'($urandom_range(1, 15));
        3: begin
          a = W'($urandom_range(0, 1000));
          b = a + W'($urandom_range(1, 1000));
        end
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      start_op(a, b);
      wait_done(cyc);
      chk("rnd_lat", 64'(cyc), (b == 0) ? 64'd0 : 64'(W));
      check_res("rnd", a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
